pwm_seq_ctrl: RTL
=================

Name: pwm_seq_ctrl

Overview:
- Sequences the four PWM compare values (CR0..CR3) from a local table, synchronously with the PWM period.
- Each period-overflow pulse from the PWM core can load the next table entry, so duty updates never tear mid-period.
- Sits between the SoC register interface and the PWM core. It replaces direct CRx writes when hardware-timed duty patterns are needed (LED breathing, motor ramps).

Parameters:
- CRX_WIDTH, 32, width of one channel compare value.
- DEPTH, 16, number of table entries (power of two, >= 2).
- RPT_WIDTH, 8, width of the per-entry repeat count.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  pulse; starts a sequence using len_i, rpt_i and loop_i.
- stop_i  in  1  pulse; aborts the sequence.
- loop_i  in  1  when 1, the sequence restarts at entry 0 after the last entry.
- len_i  in  $clog2(DEPTH+1)  number of entries in the sequence (1..DEPTH).
- rpt_i  in  RPT_WIDTH  each entry is held for rpt_i+1 periods.
- wr_en_i  in  1  table write strobe.
- wr_addr_i  in  $clog2(DEPTH)  table write index.
- wr_data_i  in  4*CRX_WIDTH  entry contents; {cr3,cr2,cr1,cr0}, cr0 in the LSBs.
- ovf_i  in  1  one-cycle pulse from the PWM core at each period wrap.
- cr_o  out  4*CRX_WIDTH  compare values driven to the PWM core.
- cr_upd_o  out  1  one-cycle pulse in the cycle after cr_o is loaded.
- idx_o  out  $clog2(DEPTH)  index of the entry currently on cr_o.
- busy_o  out  1  high in ARM or RUN.
- done_o  out  1  one-cycle pulse on normal (non-loop) completion.
- err_o  out  1  one-cycle pulse when start_i is rejected.

Behaviour:
- Reset values: cr_o=0, idx_o=0, busy_o=0, done_o=0, cr_upd_o=0, err_o=0, all table entries 0, state IDLE.
- Table: DEPTH x 4*CRX_WIDTH flops, combinational read, written on wr_en_i at any time and in any state.
  - A write and an ovf-triggered load of the same entry in the same cycle loads the OLD data; the new data is used on the next visit.
- Shadow registers: len, rpt and loop are latched on an accepted start. Changes to len_i, rpt_i or loop_i during a sequence have no effect.
- State IDLE:
  - start_i with 1 <= len_i <= DEPTH: latch shadows, idx=0, go to ARM.
  - start_i with len_i==0 or len_i>DEPTH: err_o pulses next cycle; stay in IDLE.
  - cr_o holds its last value.
- State ARM: wait for ovf_i. On ovf_i: cr_o <= table[0], idx=0, rpt_cnt <= rpt, go to RUN.
  - First new values therefore apply from the period boundary after start, never mid-period.
- State RUN, on each ovf_i:
  - rpt_cnt != 0: rpt_cnt decrements; cr_o unchanged.
  - rpt_cnt == 0 and idx < len-1: idx++, cr_o <= table[idx+1], rpt_cnt <= rpt.
  - rpt_cnt == 0, idx == len-1, loop=1: idx=0, cr_o <= table[0], rpt_cnt <= rpt.
  - rpt_cnt == 0, idx == len-1, loop=0: go to IDLE; done_o pulses next cycle; cr_o keeps the last entry.
- cr_upd_o: registered, pulses in the cycle after every cr_o load (ARM->RUN and each entry advance). It does not pulse when cr_o is unchanged.
- stop_i: from ARM or RUN, go to IDLE next cycle; cr_o and idx_o hold; no done_o pulse. In IDLE it has no effect.
- start_i while busy: ignored, no err_o.
- start_i and stop_i in the same cycle: stop wins. From IDLE this means no start and no err_o.
- ovf_i and stop_i in the same cycle: stop wins; no load, no cr_upd_o.
- ovf_i outside ARM/RUN: ignored.
- Latency: ovf_i at cycle N gives the new cr_o at N+1 and cr_upd_o at N+1.
- rpt_i=0: one period per entry. rpt_i=2^RPT_WIDTH-1: 2^RPT_WIDTH periods per entry. rpt_cnt never underflows.
- Reset mid-sequence: immediate return to reset values, including the table contents.

Test Plan:
- Basic sequence: load table entries 0..2 with cr0 = 10, 20, 30; start len=3, rpt=0, loop=0; three ovf pulses.
  -> cr0 = 10, 20, 30 after successive ovf; cr_upd_o pulses three times; done_o pulses after the 4th ovf; busy_o drops; cr0 stays 30.
- Repeat: len=2, rpt=2.
  -> each entry is held for exactly 3 ovf pulses; idx_o changes 0->1 after the 3rd ovf; done after the 6th ovf (7th pulse overall counting the ARM ovf).
- Loop and stop: len=2, loop=1, 5 ovf pulses.
  -> idx_o sequence 0,1,0,1,0; stop_i asserted together with the 6th ovf -> no load, busy_o=0, cr_o holds entry 0.
- Bad start: start with len_i=0, then with len_i=17 (DEPTH=16).
  -> err_o pulses each time; busy_o stays 0.
- Same-cycle write and load: write entry 1 with cr0=99 in the same cycle as the ovf that loads entry 1.
  -> cr0 gets the old value; with loop=1, the next visit to entry 1 loads 99.
- Async reset in RUN: assert rst_n_i mid-sequence.
  -> all outputs return to 0 immediately; a subsequent start reads table entries as 0.

Source files
------------

// File: rtl/pwm_seq_ctrl.sv
// Table-driven sequencer for the four PWM compare values; entries advance only on
// period-overflow pulses so the PWM core never sees a torn duty update.
module pwm_seq_ctrl #(
  parameter int unsigned CRX_WIDTH = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned RPT_WIDTH = 8,
  localparam int unsigned LenW     = $clog2(DEPTH + 1),
  localparam int unsigned IdxW     = $clog2(DEPTH),
  localparam int unsigned DataW    = 4 * CRX_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 loop_i,
  input  logic [LenW-1:0]      len_i,
  input  logic [RPT_WIDTH-1:0] rpt_i,
  input  logic                 wr_en_i,
  input  logic [IdxW-1:0]      wr_addr_i,
  input  logic [DataW-1:0]     wr_data_i,
  input  logic                 ovf_i,
  output logic [DataW-1:0]     cr_o,
  output logic                 cr_upd_o,
  output logic [IdxW-1:0]      idx_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {StIdle, StArm, StRun} state_e;

  state_e                state_q, state_d;
  logic [DataW-1:0]      table_q [DEPTH];
  logic [DataW-1:0]      cr_q;
  logic [IdxW-1:0]       idx_q;
  logic [LenW-1:0]       len_q;
  logic [RPT_WIDTH-1:0]  rpt_q, rpt_cnt_q;
  logic                  loop_q, upd_q, done_q, err_q;

  logic                  len_ok, last_entry;
  logic                  accept, reject, load, dec, finish;
  logic [IdxW-1:0]       load_idx;

  assign len_ok     = (len_i != '0) && (len_i <= LenW'(DEPTH));
  assign last_entry = ({1'b0, idx_q} == (len_q - LenW'(1)));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    reject   = 1'b0;
    load     = 1'b0;
    dec      = 1'b0;
    finish   = 1'b0;
    load_idx = '0;
    unique case (state_q)
      StIdle: begin
        // A simultaneous stop cancels the start entirely, including the error pulse.
        if (start_i && !stop_i) begin
          if (len_ok) begin
            accept  = 1'b1;
            state_d = StArm;
          end else begin
            reject = 1'b1;
          end
        end
      end
      StArm: begin
        if (stop_i) begin
          state_d = StIdle;
        end else if (ovf_i) begin
          load    = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (stop_i) begin
          state_d = StIdle;
        end else if (ovf_i) begin
          if (rpt_cnt_q != '0) begin
            dec = 1'b1;
          end else if (!last_entry) begin
            load     = 1'b1;
            load_idx = idx_q + IdxW'(1);
          end else if (loop_q) begin
            load = 1'b1;
          end else begin
            finish  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o   = (state_q != StIdle);
    cr_o     = cr_q;
    idx_o    = idx_q;
    cr_upd_o = upd_q;
    done_o   = done_q;
    err_o    = err_q;
  end

  // Loads read the table before this cycle's write lands, so a colliding write
  // only takes effect on the next visit to that entry.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(DEPTH); i++) table_q[i] <= '0;
    end else if (wr_en_i) begin
      table_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cr_q      <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      rpt_q     <= '0;
      rpt_cnt_q <= '0;
      loop_q    <= 1'b0;
      upd_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      upd_q  <= load;
      done_q <= finish;
      err_q  <= reject;
      if (accept) begin
        len_q  <= len_i;
        rpt_q  <= rpt_i;
        loop_q <= loop_i;
        idx_q  <= '0;
      end
      if (load) begin
        cr_q      <= table_q[load_idx];
        idx_q     <= load_idx;
        rpt_cnt_q <= rpt_q;
      end else if (dec) begin
        rpt_cnt_q <= rpt_cnt_q - RPT_WIDTH'(1);
      end
    end
  end

endmodule
